sram_1r1w_init: RTL and testbench

Parametrised behavioural 1-read/1-write SRAM, next generation of the cache and memory array models. It adds configurable width, depth and mask granularity to the plain array. A hardware init sequencer zeroes every entry after reset and holds the ports off until that finishes. Read data is registered with a valid flag, and same-cycle write-to-read forwarding is optional. It serves as the drop-in array for new tag, data and scratch memories in the single-clock tile domain.

---
 rtl/sram_pkg.sv | 46 ++++
 rtl/sram_1r1w_init_seq.sv | 44 ++++
 rtl/sram_1r1w_init.sv | 91 +++++++++
 tb/tb_sram_1r1w_init.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1r1w_init array family:
// init-state encoding, geometry helpers and write-mask expansion.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Widest word any instance may use; mask expansion works at this width.
    localparam int SRAM_MAX_W = 1024;

    localparam int DEFAULT_ADDR_W    = 6;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_MASK_GRAN = 8;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int mask_w_of(input int data_w, input int mask_gran);
        return data_w / mask_gran;
    endfunction

    localparam int DEPTH  = depth_of(DEFAULT_ADDR_W);
    localparam int MASK_W = mask_w_of(DEFAULT_DATA_W, DEFAULT_MASK_GRAN);

    function automatic logic [SRAM_MAX_W-1:0] expand_mask(
        input logic [SRAM_MAX_W-1:0] lane_mask,
        input int                    mask_gran,
        input int                    n_lanes
    );
        logic [SRAM_MAX_W-1:0] bits;
        logic [SRAM_MAX_W-1:0] lane_ones;
        logic [SRAM_MAX_W-1:0] lanes_left;
        bits       = '0;
        lane_ones  = (SRAM_MAX_W'(1) << mask_gran) - SRAM_MAX_W'(1);
        lanes_left = lane_mask;
        for (int l = 0; l < n_lanes; l++) begin
            if (lanes_left[0]) bits = bits | (lane_ones << (l * mask_gran));
            lanes_left = lanes_left >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_1r1w_init_seq.sv
// Init sequencer: sweeps every entry after reset with a zero write,
// then raises ready and holds there until the next reset.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    init_state_e       state;
    logic [ADDR_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == '1) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: ready <= 1'b1;
                default: state <= CLEAR;
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/sram_1r1w_init.sv
// 1R/1W masked SRAM with hardware zero-init and registered read data.
// Define SRAM_RW_FWD_EN to forward same-cycle same-address writes to reads.
module sram_1r1w_init
    import sram_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MASK_GRAN = DEFAULT_MASK_GRAN,
    parameter int MASK_W_P  = mask_w_of(DATA_W, MASK_GRAN)
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic                W0_en,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic [DATA_W-1:0]   W0_data,
    input  logic [MASK_W_P-1:0] W0_mask,
    input  logic                R0_en,
    input  logic [ADDR_W-1:0]   R0_addr,
    output logic [DATA_W-1:0]   R0_data,
    output logic                R0_valid
);

    localparam int N_ENTRIES = depth_of(ADDR_W);

    logic [DATA_W-1:0] ram [N_ENTRIES];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    sram_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [DATA_W-1:0] user_bits;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_bits;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    assign user_bits = DATA_W'(expand_mask(SRAM_MAX_W'(W0_mask), MASK_GRAN, MASK_W_P));
    assign rd_fire   = ready & R0_en;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        wr_en   = ready & W0_en;
        wr_addr = W0_addr;
        wr_data = W0_data;
        wr_bits = user_bits;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_bits = '1;
        end
    end

    // NOTE: the array itself has no reset; the init sweep zeroes it instead,
    // which keeps it mappable to a real SRAM macro.
    always_ff @(posedge clock) begin
        if (wr_en) ram[wr_addr] <= (ram[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
    end

`ifdef SRAM_RW_FWD_EN
    always_comb begin
        rd_word = ram[R0_addr];
        if (W0_en && (W0_addr == R0_addr))
            rd_word = (ram[R0_addr] & ~user_bits) | (W0_data & user_bits);
    end
`else
    assign rd_word = ram[R0_addr];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            R0_data  <= '0;
            R0_valid <= 1'b0;
        end else begin
            R0_valid <= rd_fire;
            if (rd_fire) R0_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_sram_1r1w_init.sv
// Directed self-checking bench for sram_1r1w_init (ADDR_W=4, DATA_W=32, 8-bit lanes).
module tb_sram_1r1w_init;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    logic              clock;
    logic              reset;
    logic              ready;
    logic              W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [DATA_W-1:0] W0_data;
    logic [MASK_W-1:0] W0_mask;
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic [DATA_W-1:0] R0_data;
    logic              R0_valid;

    int n_checks = 0;
    int n_fails  = 0;

    sram_1r1w_init #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_GRAN(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .W0_en    (W0_en),
        .W0_addr  (W0_addr),
        .W0_data  (W0_data),
        .W0_mask  (W0_mask),
        .R0_en    (R0_en),
        .R0_addr  (R0_addr),
        .R0_data  (R0_data),
        .R0_valid (R0_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [MASK_W-1:0] m);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
        tick();
        W0_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp);
        R0_en = 1'b1; R0_addr = a;
        tick();
        R0_en = 1'b0;
        n_checks++;
        if (R0_valid !== 1'b1 || R0_data !== exp) begin
            n_fails++;
            $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=1", name, R0_data, R0_valid, exp);
        end
    endtask

    task automatic test_reset();
        int cycles;
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (ready !== 1'b0 || R0_valid !== 1'b0 || R0_data !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_state: got ready=%b valid=%b data=%h, expected 0 0 00000000", ready, R0_valid, R0_data);
        end
        reset = 1'b0;
        wait_ready(cycles);
        n_checks++;
        if (cycles !== 16) begin
            n_fails++;
            $display("FAIL init_length: got %0d cycles, expected 16", cycles);
        end
    endtask

    task automatic test_read_all_zero();
        for (int a = 0; a < 16; a++) read_check("init_zero", ADDR_W'(a), 32'h0);
    endtask

    task automatic test_clear_ignores_ports();
        int cycles;
        int bad_valid;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        W0_en = 1'b1; W0_addr = 4'd2; W0_data = 32'hFFFF_FFFF; W0_mask = 4'hF;
        R0_en = 1'b1; R0_addr = 4'd2;
        cycles = 0; bad_valid = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
            if (R0_valid !== 1'b0) bad_valid++;
        end
        W0_en = 1'b0; R0_en = 1'b0;
        n_checks++;
        if (bad_valid !== 0 || cycles !== 16) begin
            n_fails++;
            $display("FAIL clear_ignore: got valid_high=%0d cycles=%0d, expected 0 and 16", bad_valid, cycles);
        end
        read_check("clear_no_write", 4'd2, 32'h0);
    endtask

    task automatic test_mask_write();
        write_word(4'd3, 32'hDEAD_BEEF, 4'hF);
        write_word(4'd3, 32'h1122_3344, 4'h5);
        read_check("mask_merge", 4'd3, 32'hDE22_BE44);
        write_word(4'd3, 32'hFFFF_FFFF, 4'h0);
        read_check("mask_zero", 4'd3, 32'hDE22_BE44);
        write_word(4'd4, 32'hCAFE_F00D, 4'hA);
        read_check("mask_upper", 4'd4, 32'hCA00_F000);
    endtask

    task automatic test_same_addr();
        logic [DATA_W-1:0] exp_fwd;
`ifdef SRAM_RW_FWD_EN
        exp_fwd = 32'h5555_5555;
`else
        exp_fwd = 32'hAAAA_AAAA;
`endif
        write_word(4'd7, 32'hAAAA_AAAA, 4'hF);
        W0_en = 1'b1; W0_addr = 4'd7; W0_data = 32'h5555_5555; W0_mask = 4'hF;
        R0_en = 1'b1; R0_addr = 4'd7;
        tick();
        W0_en = 1'b0; R0_en = 1'b0;
        n_checks++;
        if (R0_valid !== 1'b1 || R0_data !== exp_fwd) begin
            n_fails++;
            $display("FAIL same_addr: got data=%h valid=%b, expected %h", R0_data, R0_valid, exp_fwd);
        end
        read_check("same_addr_after", 4'd7, 32'h5555_5555);
        // different addresses in the same cycle are independent
        W0_en = 1'b1; W0_addr = 4'd8; W0_data = 32'h0BAD_F00D; W0_mask = 4'hF;
        R0_en = 1'b1; R0_addr = 4'd3;
        tick();
        W0_en = 1'b0; R0_en = 1'b0;
        n_checks++;
        if (R0_valid !== 1'b1 || R0_data !== 32'hDE22_BE44) begin
            n_fails++;
            $display("FAIL diff_addr: got data=%h valid=%b, expected DE22BE44", R0_data, R0_valid);
        end
        read_check("diff_addr_write", 4'd8, 32'h0BAD_F00D);
    endtask

    task automatic test_reset_midclear();
        int cycles;
        write_word(4'd5, 32'h1234_5678, 4'hF);
        read_check("pre_reset", 4'd5, 32'h1234_5678);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fails++;
            $display("FAIL midclear_ready: got %b, expected 0", ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(cycles);
        n_checks++;
        if (cycles !== 16) begin
            n_fails++;
            $display("FAIL midclear_restart: got %0d cycles, expected 16", cycles);
        end
        read_check("reclear_5", 4'd5, 32'h0);
        read_check("reclear_8", 4'd8, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp [3];
        exp[0] = 32'h0101_0101; exp[1] = 32'h0202_0202; exp[2] = 32'h0303_0303;
        for (int i = 0; i < 3; i++) write_word(ADDR_W'(i + 1), exp[i], 4'hF);
        for (int i = 0; i < 3; i++) begin
            R0_en = 1'b1; R0_addr = ADDR_W'(i + 1);
            tick();
            n_checks++;
            if (R0_valid !== 1'b1 || R0_data !== exp[i]) begin
                n_fails++;
                $display("FAIL b2b_read%0d: got data=%h valid=%b, expected %h valid=1", i, R0_data, R0_valid, exp[i]);
            end
        end
        R0_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (R0_valid !== 1'b0 || R0_data !== 32'h0303_0303) begin
                n_fails++;
                $display("FAIL b2b_hold%0d: got data=%h valid=%b, expected 03030303 valid=0", i, R0_data, R0_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        R0_en = 1'b0; R0_addr = '0;
        test_reset();
        test_read_all_zero();
        test_clear_ignores_ports();
        test_mask_write();
        test_same_addr();
        test_reset_midclear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
